gray2rgb_stream: RTL and testbench

//  Output-side inverse of the RGB888->gray converter. Expands a WIDTH-bit grayscale pixel stream
//  (e.g. sharpening-filter output) to RGB888 for the display/writeback path.

---
 rtl/gray2rgb_pkg.sv | 14 +
 rtl/pix_skid_buf.sv | 81 ++++++++
 rtl/gray2rgb_stream.sv | 137 +++++++++++++
 tb/tb_gray2rgb_stream.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray2rgb_pkg.sv
// Shared definitions for the gray<->RGB stream converters: channel width and
// the colour-mode encoding used to pick which channels a gray sample drives.
package gray2rgb_pkg;

  localparam int CH_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_R    = 2'd0,
    MODE_G    = 2'd1,
    MODE_B    = 2'd2,
    MODE_GRAY = 2'd3
  } mode_e;

endpackage

// File: rtl/pix_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The head entry is the output
// register; the tail entry catches one extra word so in_ready can be a
// registered signal with no combinational path from out_ready.
module pix_skid_buf
  import gray2rgb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          in_fire;
  logic          out_fire;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Occupancy after this cycle's accept/transfer; a simultaneous pair cancels out.
  always_comb begin
    count_d = count_q;
    case ({in_fire, out_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Entry storage: head always holds the oldest word, and is cleared when the buffer drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (count_q)
        2'd0: begin
          if (in_fire) head_q <= in_data;
        end
        2'd1: begin
          if (in_fire && out_fire) begin
            head_q <= in_data;
          end else if (in_fire) begin
            tail_q <= in_data;
          end else if (out_fire) begin
            head_q <= '0;
          end
        end
        default: begin
          if (out_fire) begin
            head_q <= tail_q;
            tail_q <= '0;
          end
        end
      endcase
    end
  end

  // Occupancy and registered ready: refuse new data only when both entries will be full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      count_q  <= count_d;
      in_ready <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/gray2rgb_stream.sv
// Expands a gray pixel stream to RGB888 for the display/writeback path.
// The colour mode is latched at the first pixel of each frame; sof/eol are
// tagged on input and carried through the skid buffer with the pixel, and
// frame_done pulses after the last pixel of a frame leaves the block.
module gray2rgb_stream
  import gray2rgb_pkg::*;
#(
  parameter int WIDTH = CH_WIDTH,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_done,
  output logic             data_in_ready,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] r_data_out,
  output logic [WIDTH-1:0] g_data_out,
  output logic [WIDTH-1:0] b_data_out,
  output logic             data_out_done,
  input  logic             data_out_ready,
  output logic             sof,
  output logic             eol,
  output logic             frame_done
);

  localparam int DW = 3 * WIDTH + 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    in_col;
  logic [RW-1:0]    in_row;
  logic [CW-1:0]    out_col;
  logic [RW-1:0]    out_row;
  mode_e            mode_q;
  mode_e            mode_eff;
  logic             in_first;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] b_in;
  logic [DW-1:0]    payload_in;
  logic [DW-1:0]    payload_out;

  assign in_fire  = data_in_done & data_in_ready;
  assign out_fire = data_out_done & data_out_ready;
  assign in_first = (in_col == '0) && (in_row == '0);

  // Channel mapping: the first pixel of a frame uses the live mode, later pixels the latched one.
  always_comb begin
    mode_eff = in_first ? mode_e'(mode) : mode_q;
    r_in     = '0;
    g_in     = '0;
    b_in     = '0;
    case (mode_eff)
      MODE_R:    r_in = data_in;
      MODE_G:    g_in = data_in;
      MODE_B:    b_in = data_in;
      MODE_GRAY: begin
        r_in = data_in;
        g_in = data_in;
        b_in = data_in;
      end
      default:   r_in = '0;
    endcase
  end

  assign payload_in = {r_in, g_in, b_in, in_first, (in_col == COL_LAST)};

  pix_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (payload_in),
    .in_valid (data_in_done),
    .in_ready (data_in_ready),
    .out_data (payload_out),
    .out_valid(data_out_done),
    .out_ready(data_out_ready)
  );

  assign {r_data_out, g_data_out, b_data_out, sof, eol} = payload_out;

  // Mode latch: sampled only when the first pixel of a frame is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_GRAY;
    end else if (in_fire && in_first) begin
      mode_q <= mode_e'(mode);
    end
  end

  // Input position counters, advancing on each accepted pixel and wrapping per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_col <= '0;
      in_row <= '0;
    end else if (in_fire) begin
      if (in_col == COL_LAST) begin
        in_col <= '0;
        in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  // Output position counters, advancing on each transferred pixel and wrapping per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_col <= '0;
      out_row <= '0;
    end else if (out_fire) begin
      if (out_col == COL_LAST) begin
        out_col <= '0;
        out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
      end else begin
        out_col <= out_col + 1'b1;
      end
    end
  end

  // One-cycle pulse after the last pixel of a frame has been handed downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_fire && (out_col == COL_LAST) && (out_row == ROW_LAST);
    end
  end

endmodule

// File: tb/tb_gray2rgb_stream.sv
// Directed bench for gray2rgb_stream on a 4x2 image: reset state, mode
// mapping and latching, backpressure, randomised handshakes, async reset
// mid-frame and sustained full throughput.
module tb_gray2rgb_stream;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_in_done;
  logic       data_in_ready;
  logic [1:0] mode;
  logic [7:0] r_data_out;
  logic [7:0] g_data_out;
  logic [7:0] b_data_out;
  logic       data_out_done;
  logic       data_out_ready;
  logic       sof;
  logic       eol;
  logic       frame_done;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];
  int   m_col;
  int   m_row;
  logic [1:0] m_mode;
  int   fd_count;
  int   out_count;
  bit   last_in_fire;
  bit   last_out_fire;

  gray2rgb_stream #(
    .WIDTH(WIDTH),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_done  (data_in_done),
    .data_in_ready (data_in_ready),
    .mode          (mode),
    .r_data_out    (r_data_out),
    .g_data_out    (g_data_out),
    .b_data_out    (b_data_out),
    .data_out_done (data_out_done),
    .data_out_ready(data_out_ready),
    .sof           (sof),
    .eol           (eol),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_col     = 0;
    m_row     = 0;
    m_mode    = 2'd3;
    fd_count  = 0;
    out_count = 0;
  endtask

  task automatic model_push(input logic [7:0] d);
    pix_t       e;
    logic [1:0] eff;
    bit         first;
    first = (m_col == 0) && (m_row == 0);
    eff   = first ? mode : m_mode;
    if (first) m_mode = mode;
    e = '0;
    case (eff)
      2'd0:    e.r = d;
      2'd1:    e.g = d;
      2'd2:    e.b = d;
      default: begin
        e.r = d;
        e.g = d;
        e.b = d;
      end
    endcase
    e.sof = first;
    e.eol = (m_col == IMG_W - 1);
    if (m_col == IMG_W - 1) begin
      m_col = 0;
      m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    exp_q.push_back(e);
  endtask

  // One clock: score the handshakes set up for this edge, then step to #1 after it.
  task automatic apply_stimulus();
    pix_t e;
    last_in_fire  = data_in_done && data_in_ready;
    last_out_fire = data_out_done && data_out_ready;
    if (last_out_fire) begin
      check_output("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("out_pixel", 32'({r_data_out, g_data_out, b_data_out, sof, eol}), 32'(e));
      end
      check_output("eol_pos", 32'(eol), 32'(out_count % IMG_W == IMG_W - 1));
      check_output("sof_pos", 32'(sof), 32'(out_count % (IMG_W * IMG_H) == 0));
      out_count++;
    end
    if (last_in_fire) model_push(data_in);
    @(posedge clk);
    #1;
    if (frame_done) fd_count++;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    data_in_done   = 1'b0;
    data_out_ready = 1'b1;
    mode           = 2'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pix_t snap;
    int   fed;
    int   cyc;

    // Test 1: reset state, then a single gray pixel with sof
    reset          = 1'b0;
    data_in        = 8'h00;
    data_in_done   = 1'b0;
    data_out_ready = 1'b1;
    mode           = 2'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_done", 32'(data_out_done), 32'd0);
    check_output("rst_ready", 32'(data_in_ready), 32'd0);
    check_output("rst_rgb", 32'({r_data_out, g_data_out, b_data_out}), 32'd0);
    check_output("rst_sideband", 32'({sof, eol, frame_done}), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("t1_ready_after_release", 32'(data_in_ready), 32'd1);
    data_in      = 8'h5A;
    data_in_done = 1'b1;
    apply_stimulus();
    data_in_done = 1'b0;
    check_output("t1_rgb", 32'({r_data_out, g_data_out, b_data_out}), 32'h5A5A5A);
    check_output("t1_done", 32'(data_out_done), 32'd1);
    check_output("t1_sof", 32'(sof), 32'd1);
    apply_stimulus();
    check_output("t1_drained", 32'(data_out_done), 32'd0);

    // Test 2: red-only frame with a mid-frame mode change, then a blue frame
    do_reset();
    mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      data_in      = 8'(8'h10 + i);
      data_in_done = 1'b1;
      apply_stimulus();
      check_output("t2_rgb", 32'({r_data_out, g_data_out, b_data_out}), {8'h00, 8'(8'h10 + i), 16'h0000});
      if (i == 3) mode = 2'd2;
    end
    data_in_done = 1'b0;
    repeat (3) apply_stimulus();
    check_output("t2_frame_done", 32'(fd_count), 32'd1);
    data_in      = 8'h77;
    data_in_done = 1'b1;
    apply_stimulus();
    data_in_done = 1'b0;
    check_output("t2_next_frame_rgb", 32'({r_data_out, g_data_out, b_data_out}), 32'h000077);
    check_output("t2_next_frame_sof", 32'(sof), 32'd1);
    apply_stimulus();

    // Test 3: downstream stall for 5 cycles with continuous input
    do_reset();
    data_out_ready = 1'b0;
    data_in        = 8'd1;
    data_in_done   = 1'b1;
    apply_stimulus();
    data_in = 8'd2;
    apply_stimulus();
    snap    = {r_data_out, g_data_out, b_data_out, sof, eol};
    data_in = 8'd3;
    repeat (3) apply_stimulus();
    check_output("t3_ready_low", 32'(data_in_ready), 32'd0);
    check_output("t3_head", 32'({r_data_out, data_out_done}), 32'h0003);
    check_output("t3_stable", 32'({r_data_out, g_data_out, b_data_out, sof, eol}), 32'(snap));
    data_out_ready = 1'b1;
    apply_stimulus();
    check_output("t3_second", 32'(r_data_out), 32'd2);
    apply_stimulus();
    check_output("t3_accept3", 32'(last_in_fire), 32'd1);
    data_in_done = 1'b0;
    check_output("t3_third", 32'(r_data_out), 32'd3);
    repeat (2) apply_stimulus();
    check_output("t3_no_loss", 32'(exp_q.size()), 32'd0);
    check_output("t3_no_dup", 32'(out_count), 32'd3);

    // Test 4: random valid/ready over 3 frames with mode changing every cycle
    do_reset();
    fed = 0;
    cyc = 0;
    while ((fed < 24 || exp_q.size() != 0 || data_out_done) && cyc < 3000) begin
      if (fed < 24) begin
        if (!data_in_done) begin
          data_in      = 8'($urandom);
          data_in_done = ($urandom_range(0, 2) != 0);
        end
      end else begin
        data_in_done = 1'b0;
      end
      data_out_ready = ($urandom_range(0, 2) != 0);
      mode           = 2'($urandom);
      apply_stimulus();
      if (last_in_fire) begin
        fed++;
        data_in_done = 1'b0;
      end
      cyc++;
    end
    data_out_ready = 1'b1;
    apply_stimulus();
    check_output("t4_in_time", 32'(cyc < 3000), 32'd1);
    check_output("t4_frames", 32'(fd_count), 32'd3);
    check_output("t4_outputs", 32'(out_count), 32'd24);

    // Test 5: async reset with the buffer full
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      data_in      = 8'(i);
      data_in_done = 1'b1;
      apply_stimulus();
    end
    data_out_ready = 1'b0;
    data_in        = 8'd5;
    apply_stimulus();
    check_output("t5_full", 32'(data_in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_output("t5_async_done", 32'(data_out_done), 32'd0);
    check_output("t5_async_rgb", 32'({r_data_out, g_data_out, b_data_out, sof, eol}), 32'd0);
    data_in_done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    mode           = 2'd3;
    data_in        = 8'h99;
    data_in_done   = 1'b1;
    apply_stimulus();
    data_in_done = 1'b0;
    check_output("t5_first_rgb", 32'({r_data_out, g_data_out, b_data_out}), 32'h999999);
    check_output("t5_first_sof", 32'(sof), 32'd1);
    apply_stimulus();

    // Test 6: one pixel per cycle, green mode, two full frames
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      data_in      = 8'(i * 3);
      data_in_done = 1'b1;
      check_output("t6_ready", 32'(data_in_ready), 32'd1);
      apply_stimulus();
      check_output("t6_accept", 32'(last_in_fire), 32'd1);
    end
    data_in_done = 1'b0;
    repeat (3) apply_stimulus();
    check_output("t6_frames", 32'(fd_count), 32'd2);
    check_output("t6_outputs", 32'(out_count), 32'd16);
    check_output("t6_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
